// File: rtl/key_pkg.sv
// Shared types and constants for the key debounce / press-pulse slice.
package key_pkg;

  typedef enum logic [1:0] {IDLE, PFILT, DOWN, RFILT} key_st_e;

  // Board pins idle high; a pressed key pulls the pin low.
  localparam logic KEY_RELEASED = 1'b1;
  localparam int   NKEY_DEFAULT = 5;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/key_pulse_gen_if.sv
// Key-event bus: raw pins in, clean press pulses and debounced levels out.
interface key_pulse_gen_if
  import key_pkg::*;
#(
  parameter int NKEY = NKEY_DEFAULT
);
  logic [NKEY-1:0] Key_In;
  logic [NKEY-1:0] Key_Pulse;
  logic [NKEY-1:0] Key_Level;

  modport master (input Key_In, output Key_Pulse, output Key_Level);
  modport slave  (output Key_In, input Key_Pulse, input Key_Level);
endinterface

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchronizer, debounce FSM, counter, pulse/level regs.
// Auto-repeat while held is compiled in with KEY_REPEAT_EN.
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYC   = 1_000_000,
  parameter int REPEAT_DLY_CYC = 25_000_000,
  parameter int REPEAT_CYC     = 5_000_000
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic key_in,
  output logic key_pulse,
  output logic key_level
);
  localparam int CW = $clog2(max3(DEBOUNCE_CYC, REPEAT_DLY_CYC, REPEAT_CYC) + 1);
  localparam logic [CW-1:0] DB_TERM = CW'(DEBOUNCE_CYC - 1);

  logic [1:0]    sync;
  logic          s_prs;
  key_st_e       st, st_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          db_done;
  logic          pulse_nxt, level_nxt;

`ifdef KEY_REPEAT_EN
  localparam logic [CW-1:0] RD_TERM = CW'(REPEAT_DLY_CYC - 1);
  localparam logic [CW-1:0] RC_TERM = CW'(REPEAT_CYC - 1);
  // rpt: first repeat already issued, so further ones use the shorter period
  logic rpt, rpt_nxt;
  logic rpt_done;
  assign rpt_done = rpt ? (cnt == RC_TERM) : (cnt == RD_TERM);
`endif

  assign s_prs   = (sync[1] != KEY_RELEASED);
  assign db_done = (cnt == DB_TERM);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      sync      <= {KEY_RELEASED, KEY_RELEASED};
      st        <= IDLE;
      cnt       <= '0;
      key_pulse <= 1'b0;
      key_level <= 1'b0;
`ifdef KEY_REPEAT_EN
      rpt       <= 1'b0;
`endif
    end else begin
      sync      <= {sync[0], key_in};
      st        <= st_nxt;
      cnt       <= cnt_nxt;
      key_pulse <= pulse_nxt;
      key_level <= level_nxt;
`ifdef KEY_REPEAT_EN
      rpt       <= rpt_nxt;
`endif
    end
  end

  always_comb begin
    st_nxt = st;
    unique case (st)
      IDLE:    if (s_prs) st_nxt = PFILT;
      PFILT:   if (!s_prs) st_nxt = IDLE; else if (db_done) st_nxt = DOWN;
      DOWN:    if (!s_prs) st_nxt = RFILT;
      RFILT:   if (s_prs) st_nxt = DOWN; else if (db_done) st_nxt = IDLE;
      default: st_nxt = IDLE;
    endcase
  end

  // Counter is cleared on every state change, so it never wraps.
  always_comb begin
    cnt_nxt   = '0;
    pulse_nxt = 1'b0;
    level_nxt = (st_nxt == DOWN) || (st_nxt == RFILT);
`ifdef KEY_REPEAT_EN
    rpt_nxt   = rpt;
`endif
    unique case (st)
      PFILT, RFILT: if (st_nxt == st) cnt_nxt = cnt + 1'b1;
      DOWN: begin
`ifdef KEY_REPEAT_EN
        if (s_prs) begin
          if (rpt_done) begin
            pulse_nxt = 1'b1;
            rpt_nxt   = 1'b1;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
`endif
      end
      default: ;
    endcase
    if (st == PFILT && st_nxt == DOWN) pulse_nxt = 1'b1;
`ifdef KEY_REPEAT_EN
    if (st_nxt == DOWN && st != DOWN) rpt_nxt = 1'b0;
`endif
  end

endmodule

// File: rtl/key_pulse_gen.sv
// Debounced single-cycle press pulses for NKEY active-low push buttons.
// Optional auto-repeat while held: define KEY_REPEAT_EN.
module key_pulse_gen
  import key_pkg::*;
#(
  parameter int NKEY           = NKEY_DEFAULT,
  parameter int DEBOUNCE_CYC   = 1_000_000,
  parameter int REPEAT_DLY_CYC = 25_000_000,
  parameter int REPEAT_CYC     = 5_000_000
) (
  input  logic            CLK,
  input  logic            RSTn,
  key_pulse_gen_if.master kif
);

  for (genvar i = 0; i < NKEY; i++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYC  (DEBOUNCE_CYC),
      .REPEAT_DLY_CYC(REPEAT_DLY_CYC),
      .REPEAT_CYC    (REPEAT_CYC)
    ) u_ch (
      .CLK      (CLK),
      .RSTn     (RSTn),
      .key_in   (kif.Key_In[i]),
      .key_pulse(kif.Key_Pulse[i]),
      .key_level(kif.Key_Level[i])
    );
  end

endmodule

// File: tb/tb_key_pulse_gen.sv
// Bench for key_pulse_gen: directed scenarios plus random bouncing keys vs a run-length model.
module tb_key_pulse_gen;
  import key_pkg::*;

  localparam int NK = 5, DB = 8, RD = 20, RC = 10;
`ifdef KEY_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RSTn;
  always #5 CLK = ~CLK;

  key_pulse_gen_if #(.NKEY(NK)) kif();

  key_pulse_gen #(
    .NKEY(NK), .DEBOUNCE_CYC(DB), .REPEAT_DLY_CYC(RD), .REPEAT_CYC(RC)
  ) dut (
    .CLK (CLK),
    .RSTn(RSTn),
    .kif (kif)
  );

  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: a level flips once D+1 consecutive opposite samples arrive
  // (pins are seen two clocks late); holding a press yields repeat pulses.
  logic [NK-1:0] m_lvl, m_h1, m_h2, m_rep, exp_p, exp_l;
  int            m_run[NK];
  int            m_hold[NK];

  task automatic model_reset();
    m_lvl = '0; m_rep = '0; exp_p = '0; exp_l = '0;
    m_h1 = {NK{KEY_RELEASED}}; m_h2 = {NK{KEY_RELEASED}};
    for (int k = 0; k < NK; k++) begin m_run[k] = 0; m_hold[k] = 0; end
  endtask

  task automatic model_step(input logic [NK-1:0] raw);
    for (int k = 0; k < NK; k++) begin
      bit x;
      x = (m_h2[k] != KEY_RELEASED);
      m_h2[k] = m_h1[k];
      m_h1[k] = raw[k];
      exp_p[k] = 1'b0;
      if (!m_lvl[k]) begin
        if (x) begin
          m_run[k]++;
          if (m_run[k] == DB + 1) begin
            m_lvl[k] = 1'b1; exp_p[k] = 1'b1; m_run[k] = 0; m_hold[k] = 0; m_rep[k] = 1'b0;
          end
        end else m_run[k] = 0;
      end else if (!x) begin
        m_run[k]++;
        if (m_run[k] == DB + 1) begin m_lvl[k] = 1'b0; m_run[k] = 0; end
      end else if (m_run[k] > 0) begin
        m_run[k] = 0; m_hold[k] = 0; m_rep[k] = 1'b0;
      end else begin
        m_hold[k]++;
        if (REP_EN && m_hold[k] == (m_rep[k] ? RC : RD)) begin
          exp_p[k] = 1'b1; m_hold[k] = 0; m_rep[k] = 1'b1;
        end
      end
    end
    exp_l = m_lvl;
  endtask

  // Scenario bookkeeping, all taken from observed DUT outputs.
  int cyc;
  int npulse[NK];
  int lastp[NK];
  int q0[$];

  task automatic clr_stats();
    cyc = 0;
    q0.delete();
    for (int k = 0; k < NK; k++) begin npulse[k] = 0; lastp[k] = -1; end
  endtask

  task automatic tick(input logic [NK-1:0] raw, input logic rst_n);
    @(negedge CLK);
    kif.Key_In = raw;
    RSTn = rst_n;
    if (!rst_n) begin
      #1;
      chk("async_rst_pulse", {27'd0, kif.Key_Pulse}, 32'd0);
      chk("async_rst_level", {27'd0, kif.Key_Level}, 32'd0);
    end
    @(posedge CLK);
    #1;
    if (rst_n) model_step(raw);
    else       model_reset();
    chk("pulse", {27'd0, kif.Key_Pulse}, {27'd0, exp_p});
    chk("level", {27'd0, kif.Key_Level}, {27'd0, exp_l});
    for (int k = 0; k < NK; k++)
      if (kif.Key_Pulse[k]) begin npulse[k]++; lastp[k] = cyc; end
    if (kif.Key_Pulse[0]) q0.push_back(cyc);
    cyc++;
  endtask

  task automatic run(input logic [NK-1:0] raw, input int n);
    for (int i = 0; i < n; i++) tick(raw, 1'b1);
  endtask

  localparam logic [NK-1:0] REL = {NK{1'b1}};

  logic [NK-1:0] cur;
  int            left[NK];
  int            rst_left;
  int            exp_q[5];

  initial begin
    RSTn = 1'b0;
    kif.Key_In = REL;
    model_reset();
    clr_stats();
    for (int i = 0; i < 3; i++) tick(REL, 1'b0);
    run(REL, 4);

    // Clean press on key 0, then clean release.
    clr_stats();
    run(REL & ~5'b00001, 15);
    chk("clean_npulse0", npulse[0], 1);
    chk("clean_pcyc0", lastp[0], 10);
    chk("clean_others", npulse[1] + npulse[2] + npulse[3] + npulse[4], 0);
    chk("clean_level0", kif.Key_Level[0], 1);
    clr_stats();
    run(REL, 10);
    chk("rel_level_c9", kif.Key_Level[0], 1);
    run(REL, 1);
    chk("rel_level_c10", kif.Key_Level[0], 0);
    run(REL, 4);

    // Bouncing press on key 2.
    clr_stats();
    run(REL & ~5'b00100, 3); run(REL, 2); run(REL & ~5'b00100, 5); run(REL, 10);
    chk("bounce_npulse2", npulse[2], 0);
    chk("bounce_level2", kif.Key_Level[2], 0);
    clr_stats();
    run(REL & ~5'b00100, 14);
    chk("bounce_final_pcyc", lastp[2], 10);
    chk("bounce_final_n", npulse[2], 1);

    // Release of key 2 with a 4-cycle glitch back to low.
    run(REL & ~5'b00100, 4);
    clr_stats();
    run(REL, 3); run(REL & ~5'b00100, 4);
    cyc = 0;
    run(REL, 10);
    chk("relb_level_c9", kif.Key_Level[2], 1);
    run(REL, 1);
    chk("relb_level_c10", kif.Key_Level[2], 0);
    chk("relb_npulse", npulse[2], 0);
    run(REL, 4);

    // Simultaneous press on keys 4 and 1.
    clr_stats();
    run(REL & ~5'b10010, 11);
    chk("simul_vec", {27'd0, kif.Key_Pulse}, 32'h12);
    run(REL & ~5'b10010, 3);
    chk("simul_n", npulse[1] + npulse[4], 2);
    run(REL, 14);

    // Reset while key 3 is mid-filter, key held through reset.
    clr_stats();
    run(REL & ~5'b01000, 8);
    for (int i = 0; i < 3; i++) tick(REL & ~5'b01000, 1'b0);
    clr_stats();
    run(REL & ~5'b01000, 14);
    chk("rst_pcyc3", lastp[3], 10);
    chk("rst_n3", npulse[3], 1);
    run(REL, 14);

    // Long hold on key 0: repeat pulses only with KEY_REPEAT_EN.
    clr_stats();
    run(REL & ~5'b00001, 60);
    run(REL, 25);
    exp_q = REP_EN ? '{10, 30, 40, 50, 60} : '{10, -1, -1, -1, -1};
    chk("hold_npulse", q0.size(), REP_EN ? 5 : 1);
    for (int i = 0; i < 5; i++)
      if (i < q0.size()) chk("hold_pcyc", q0[i], exp_q[i]);

    // Random bouncing on all keys with occasional resets.
    cur = REL;
    rst_left = 0;
    for (int k = 0; k < NK; k++) left[k] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < NK; k++) begin
        if (left[k] == 0) begin
          cur[k] = ~cur[k];
          left[k] = ($urandom_range(0, 4) == 0) ? int'($urandom_range(15, 45))
                                                : int'($urandom_range(1, 12));
        end
        left[k]--;
      end
      if (rst_left == 0 && $urandom_range(0, 499) == 0) rst_left = int'($urandom_range(1, 3));
      if (rst_left > 0) begin
        rst_left--;
        tick(cur, 1'b0);
      end else begin
        tick(cur, 1'b1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/key_pulse_gen.md
# key_pulse_gen

Producer side of the key-event interface: converts raw, bouncing, active-low push-button pins into clean single-cycle active-high press pulses, one bit per key, consumed by the key-toggle and LED logic downstream. Each key has its own synchronizer, debounce filter and edge generator. The block sits directly behind the board key pins. Its `Key_Pulse` bus drives the `Key_Input` bus of the consumer.

## Interface
- `NKEY`, default 5: number of independent keys.
- `DEBOUNCE_CYC`, default 1_000_000: consecutive stable cycles needed to accept a level change (20 ms at 50 MHz); must be ≥ 2.
- `REPEAT_DLY_CYC`, default 25_000_000: held cycles before the first auto-repeat pulse. Used only with `KEY_REPEAT_EN`.
- `REPEAT_CYC`, default 5_000_000: cycles between subsequent auto-repeat pulses. Used only with `KEY_REPEAT_EN`.
- `CLK`, input, 1: single clock.
- `RSTn`, input, 1: asynchronous, active-low reset.
- `Key_In`, input, `NKEY`: raw key pins, asynchronous. 0 = pressed, 1 = released.
- `Key_Pulse`, output, `NKEY`: registered, one-cycle high per accepted press (and per repeat event when enabled).
- `Key_Level`, output, `NKEY`: registered debounced state. 1 = pressed.

## Operation
- Per key: a 2-flop synchronizer on `Key_In[i]` produces `s`, which is inverted to pressed = 1.
- Per-key FSM:
  - IDLE: released. If `s` = pressed, clear the counter and go to PFILT.
  - PFILT:
    - If `s` = released, go to IDLE and clear the counter.
    - Otherwise increment. When count = `DEBOUNCE_CYC`-1, go to DOWN, set `Key_Level`, and pulse `Key_Pulse` for one cycle.
  - DOWN: pressed. If `s` = released, clear the counter and go to RFILT.
  - RFILT:
    - If `s` = pressed, go to DOWN with no new pulse.
    - Otherwise increment. When count = `DEBOUNCE_CYC`-1, go to IDLE and clear `Key_Level`. No pulse on release.
- A bounce shorter than `DEBOUNCE_CYC` cycles restarts filtering and never produces a pulse.
- Keys are fully independent. Simultaneous presses give coincident pulses on several bits; prioritisation is the consumer's job.
- Counter width is `$clog2(max(DEBOUNCE_CYC, REPEAT_DLY_CYC, REPEAT_CYC)+1)`, unsigned, per key. The counter never wraps: it is always cleared on a state change or a terminal count.

## Timing
- Reset values:
  - all FSMs in IDLE;
  - synchronizer flops = 1 (released);
  - counters = 0;
  - `Key_Pulse` = 0 and `Key_Level` = 0.
- Latency: raw press stable from sample edge 0 gives `Key_Pulse` high during cycle 2+`DEBOUNCE_CYC` (2 synchronizer + `DEBOUNCE_CYC` filter), exactly one cycle wide.
- `Key_Level` rises in the same cycle as the press pulse. It falls 2+`DEBOUNCE_CYC` cycles after a stable release.
- `RSTn` asserted mid-filter or mid-hold returns immediately to reset values. A key held through reset deassertion is re-filtered from IDLE, so exactly one pulse follows `DEBOUNCE_CYC`+2 cycles later.
- There is no handshake. The consumer must sample `Key_Pulse` every cycle.

## Configuration
- `KEY_REPEAT_EN` defined:
  - in DOWN, the counter runs while held;
  - at `REPEAT_DLY_CYC` held cycles after the press pulse, emit a pulse, then one every `REPEAT_CYC` cycles until release enters RFILT;
  - a return from RFILT to DOWN restarts the repeat-delay count.
- `KEY_REPEAT_EN` undefined: exactly one pulse per accepted press. `REPEAT_*` parameters are ignored and the DOWN counter logic is removed.

## Structure
- Package `key_pkg`:
  - FSM state enum (IDLE, PFILT, DOWN, RFILT);
  - `KEY_RELEASED` = 1'b1 pin-polarity constant;
  - default `NKEY`.
- Sub-module `key_debounce_ch`: one channel (synchronizer, FSM, counter, pulse/level registers). Top-level `key_pulse_gen` instantiates it `NKEY` times in a generate loop.

## Test plan
All scenarios use `DEBOUNCE_CYC`=8, `REPEAT_DLY_CYC`=20, `REPEAT_CYC`=10.
- Clean press: `Key_In[0]` goes 1→0 at cycle 0 and is held → `Key_Pulse[0]` high only in cycle 10, `Key_Level[0]`=1 from cycle 10; other bits stay 0.
- Bounce: `Key_In[2]` toggles low 3 cycles, high 2, low 5, high → no pulse, `Key_Level[2]` stays 0. A final stable low gives a pulse 10 cycles after the last falling edge.
- Release bounce: a held key is released with a 4-cycle glitch back to low → no second pulse. `Key_Level` falls 10 cycles after the last rising edge.
- Simultaneous: `Key_In[4]` and `Key_In[1]` go low in the same cycle → `Key_Pulse`=5'b10010 in a single cycle.
- Reset mid-operation: `RSTn` pulsed low while key 3 is in PFILT (count 5), key held → outputs 0 during reset; one pulse exactly 10 cycles after `RSTn` rises.
- `KEY_REPEAT_EN`: key held 60 cycles → pulses at cycles 10, 30, 40, 50, 60; none after release. Without the macro, only cycle 10.
